mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that drives the 2-bit select and valid for the downstream 4-to-1 data mux (mux1b4to1-style stage).
- Four upstream sources raise requests; the block grants one source at a time and holds the select stable for a bounded burst.
- Handshakes with the consumer behind the mux via out_ready.
- Sits directly upstream of the mux: sel feeds the mux select, and gnt returns to the sources as their per-source acknowledge.

Parameters:
- MAX_HOLD, 4: maximum accepted beats per grant before forced rotation; legal range 1..15.
- CNT_W, 4: beat counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-source request; req[i] high means source i has data on mux input i.
- out_ready  input  1  downstream consumer accepts the current beat.
- sel  output  2  mux select, binary index of the granted source.
- sel_valid  output  1  sel is valid and the mux output carries a beat.
- gnt  output  4  one-hot grant, equal to decode(sel) when sel_valid is high, else 0.
- beat  output  1  registered pulse, high for one cycle after each accepted beat.

Behaviour:
- All outputs are registered.
- Reset is asynchronous on rst_n low: sel=2'b00, sel_valid=0, gnt=4'b0000, beat=0, beat_cnt=0, rotation pointer ptr=0, state=IDLE. Reset mid-burst drops the grant immediately with no completion.
- Accept condition: sel_valid && out_ready at a rising edge.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner as the first set bit of req scanning ptr, ptr+1, ... mod 4.
  - Next edge: sel=winner, gnt=onehot(winner), sel_valid=1, beat_cnt=0, go to GRANT.
  - Latency from req to sel_valid is 1 cycle.
- GRANT:
  - On an accepted beat: beat_cnt+1, and beat=1 on the next cycle.
  - Release when either condition holds at an edge:
    - (a) req[sel]==0, sampled at the edge; any beat accepted in that same cycle still counts.
    - (b) an accepted beat brings beat_cnt to MAX_HOLD.
  - On release: ptr = sel+1 mod 4.
    - If any other req bit is set, re-arbitrate from the new ptr in the same edge. The next grant is back-to-back, with no idle bubble; sel_valid stays 1 and beat_cnt resets to 0.
    - If only the released source still requests, after a MAX_HOLD release it is re-granted back-to-back with beat_cnt=0.
    - If req==0, go to IDLE and set sel_valid=0, gnt=0. sel keeps its last value.
- sel stays stable while sel_valid is high and no release occurs, whatever out_ready does (stall holds).
- If out_ready is low for many cycles, hold indefinitely; there is no timeout.
- Request arrivals from other sources during a grant do not preempt it.
- ptr wraps 3 to 0. beat_cnt never exceeds MAX_HOLD.

Decomposition:
- Shared package mux_sel_pkg holds:
  - localparam N_SRC=4 and SEL_W=2.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - function onehot2 (2-bit to 4-bit decode).
- One sub-module: rr_pick4. It is combinational: req[3:0] and ptr[1:0] in; winner[1:0] and any out.
- Top holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset: rst_n low with req=4'b1111 → sel=00, sel_valid=0, gnt=0000. Release reset → 1 cycle later sel=00, gnt=0001.
- Single source, streaming: req=0100, out_ready=1, MAX_HOLD=4 → sel=10 for 4 accepts, then re-granted back-to-back, beat pulses continuous. Drop req → sel_valid=0 the cycle after.
- Full rotation: req=1111, out_ready=1 → grant order 0,1,2,3,0, each for exactly 4 beats, sel_valid never low.
- Stall: grant to source 1, out_ready=0 for 10 cycles → sel=01 stable, beat=0, beat_cnt unchanged. Raise out_ready → beats resume and count continues.
- Early release: req=0011, source 0 drops req after 2 beats → next edge sel=01, beat_cnt=0. Then ptr=1, so a new req[0] waits until source 1 releases.
- Async reset mid-burst: rst_n pulses low for half a cycle during a grant to source 3 → outputs clear immediately without waiting for an edge. After release, arbitration restarts with ptr=0.

Source files
------------

// File: rtl/mux_sel_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_sel_pkg
// Shared definitions for the mux select arbiter slice:
//   N_SRC        number of upstream sources (mux inputs)
//   SEL_W        width of the binary mux select
//   arb_state_t  arbiter FSM states
//   onehot2      binary select -> one-hot grant decode
// -----------------------------------------------------------------------------
package mux_sel_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_SRC-1:0] onehot2(input logic [SEL_W-1:0] s);
    onehot2    = '0;
    onehot2[s] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_sel_arbiter_if
// Bundles the request/select/handshake signals between the sources, the
// arbiter and the downstream 4-to-1 mux consumer.
//   req        per-source request (source i has data on mux input i)
//   out_ready  consumer accepts the current beat
//   sel        mux select (binary index of the granted source)
//   sel_valid  sel is valid, mux output carries a beat
//   gnt        one-hot per-source acknowledge
//   beat       one-cycle pulse after each accepted beat
// Modports:
//   master  the arbiter (drives sel/sel_valid/gnt/beat)
//   slave   sources + consumer side (drive req/out_ready)
// -----------------------------------------------------------------------------
interface mux_sel_arbiter_if;
  import mux_sel_pkg::*;

  logic [N_SRC-1:0] req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic [N_SRC-1:0] gnt;
  logic             beat;

  modport master (
    input  req, out_ready,
    output sel, sel_valid, gnt, beat
  );

  modport slave (
    output req, out_ready,
    input  sel, sel_valid, gnt, beat
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick4.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker for four requesters.
//   req     request vector
//   ptr     highest-priority index; scan order is ptr, ptr+1, ... mod 4
//   winner  first set request bit in scan order (0 when none)
//   any     at least one request is set
// -----------------------------------------------------------------------------
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value unassigned and no latch forms.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    // Scan from the farthest offset down so the nearest request to ptr is
    // the last one written and therefore wins. The 2-bit add wraps 3 -> 0.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin arbiter producing the select for a downstream 4-to-1 data mux.
// One source is granted at a time; the grant lasts until the source drops its
// request or MAX_HOLD beats have been accepted, then rotates. All outputs are
// registered.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_sel_arbiter_if.master (req, out_ready in; sel, sel_valid,
//          gnt, beat out)
// Parameters:
//   MAX_HOLD  accepted beats per grant before forced rotation (1..15)
//   CNT_W     beat counter width, 2**CNT_W must exceed MAX_HOLD
// -----------------------------------------------------------------------------
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_sel_arbiter_if.master bus
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             valid_q, valid_d;
  logic [N_SRC-1:0] gnt_q,   gnt_d;
  logic             beat_q,  beat_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic             release_now;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] winner;
  logic             pick_any;

  assign accept  = valid_q & bus.out_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // While granted, the picker already looks from the post-release pointer so
  // a release can hand over to the next source in the same edge.
  assign pick_ptr = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;

  assign release_now = ~bus.req[sel_q] | (accept & (cnt_inc == CNT_W'(MAX_HOLD)));

  rr_pick4 u_pick (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    beat_d  = accept;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          sel_d   = winner;
          valid_d = 1'b1;
          gnt_d   = onehot2(winner);
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (accept) cnt_d = cnt_inc;
        if (release_now) begin
          ptr_d = pick_ptr;
          cnt_d = '0;
          if (pick_any) begin
            // Back-to-back handover (possibly to the same source when it is
            // the only requester left); sel_valid stays high.
            sel_d = winner;
            gnt_d = onehot2(winner);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            gnt_d   = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, and every
  // register is cleared by the asynchronous reset so a mid-burst reset drops
  // the grant at once without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
      beat_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.gnt       = gnt_q;
  assign bus.beat      = beat_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Self-checking bench for mux_sel_arbiter. Inputs change on the falling edge;
// at that moment a behavioural model predicts the outputs after the next
// rising edge and queues them. A monitor compares them 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 4;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [3:0] g;
    logic       b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  mux_sel_arbiter_if bus ();

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t exp_q[$];

  // Reference model state: who owns the mux, beats taken in this grant, and
  // where the next round-robin scan starts.
  bit m_valid;
  int m_owner;
  int m_beats;
  int m_ptr;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_ptr   = 0;
  endtask

  // Drive inputs and predict what the DUT shows after the next rising edge.
  task automatic apply(input logic [3:0] r, input logic rd);
    exp_t e;
    bit   accepted;
    bus.req       = r;
    bus.out_ready = rd;
    accepted      = m_valid && rd;
    if (!m_valid) begin
      if (r != 4'b0) begin
        m_owner = first_from(r, m_ptr);
        m_valid = 1'b1;
        m_beats = 0;
      end
    end else begin
      if (accepted) m_beats++;
      if (!r[m_owner] || m_beats == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 4;
        m_beats = 0;
        if (r != 4'b0) m_owner = first_from(r, m_ptr);
        else           m_valid = 1'b0;
      end
    end
    e.v = m_valid;
    e.s = 2'(m_owner);
    e.g = m_valid ? 4'(1 << m_owner) : 4'b0;
    e.b = accepted;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r, input logic rd);
    @(negedge clk);
    apply(r, rd);
  endtask

  // Monitor: compare queued predictions against the DUT after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sel_valid", int'(bus.sel_valid), int'(e.v));
      check("sel",       int'(bus.sel),       int'(e.s));
      check("gnt",       int'(bus.gnt),       int'(e.g));
      check("beat",      int'(bus.beat),      int'(e.b));
    end
  end

  logic [3:0] rreq;

  initial begin
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset state while all sources request.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel",       int'(bus.sel),       0);
    check("rst_sel_valid", int'(bus.sel_valid), 0);
    check("rst_gnt",       int'(bus.gnt),       0);
    check("rst_beat",      int'(bus.beat),      0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1111, 1'b1);
    @(posedge clk);
    #1;
    check("first_gnt", int'(bus.gnt), 1);

    // Single source streaming, forced rotation back to itself, then drop.
    repeat (12) cycle(4'b0100, 1'b1);
    repeat (2)  cycle(4'b0000, 1'b1);

    // Full rotation, every source requesting.
    repeat (22) cycle(4'b1111, 1'b1);
    repeat (2)  cycle(4'b0000, 1'b1);

    // Stall on source 1, then resume.
    cycle(4'b0010, 1'b1);
    repeat (10) cycle(4'b0010, 1'b0);
    @(posedge clk);
    #1;
    check("stall_sel", int'(bus.sel), 1);
    repeat (6) cycle(4'b0010, 1'b1);
    cycle(4'b0000, 1'b1);

    // Early release: source 0 leaves after two beats, source 1 takes over;
    // a returning source 0 must wait for source 1 to finish.
    cycle(4'b0011, 1'b1);
    repeat (2) cycle(4'b0011, 1'b1);
    cycle(4'b0010, 1'b1);
    repeat (6) cycle(4'b0011, 1'b1);
    cycle(4'b0000, 1'b1);

    // Randomised traffic with persistent requests.
    rreq = 4'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) rreq = rreq ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) rreq = 4'b1111;
      cycle(rreq, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset during a grant to source 3.
    cycle(4'b0000, 1'b1);
    cycle(4'b1000, 1'b0);
    repeat (3) cycle(4'b1000, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_sel", int'(bus.sel), 3);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    #1;
    check("async_sel_valid", int'(bus.sel_valid), 0);
    check("async_gnt",       int'(bus.gnt),       0);
    check("async_sel",       int'(bus.sel),       0);
    #4;
    rst_n = 1'b1;
    cycle(4'b1111, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst_sel", int'(bus.sel), 0);

    // More random traffic after the reset.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) rreq = rreq ^ 4'(1 << $urandom_range(0, 3));
      cycle(rreq, ($urandom_range(0, 4) != 0));
    end
    cycle(4'b0000, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
